// File: rtl/bus_step_controller.sv
// 68000 bus-cycle capture and single-step controller: snapshots each bus cycle for the
// SPI monitor and generates DTACK, step holds and CPU reset from the monitor command byte.
module bus_step_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,
  input  logic                 AS_N_IN,
  input  logic                 UDS_N_IN,
  input  logic                 LDS_N_IN,
  input  logic                 RW_IN,
  input  logic [22:0]          ADDR_IN,
  input  logic [15:0]          DATA_IN,
  input  logic [7:0]           CMD_IN,
  output logic                 DTACK_N,
  output logic                 CPU_RESET_N,
  output logic [23:0]          CAP_ADDR,
  output logic [15:0]          CAP_DATA,
  output logic [7:0]           CAP_STATUS,
  output logic [CNT_WIDTH-1:0] CYCLE_COUNT
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_ACK} state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  logic [2:0]           r_strb_s1;
  logic [2:0]           r_strb_s2;
  logic [7:0]           r_cmd_s1;
  logic [7:0]           r_cmd_s2;
  logic [7:0]           r_cmd_prev;
  logic [2:0]           r_cmd;
  logic                 r_toggle_prev;
  logic                 r_cpu_reset_n;
  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_wait_cnt;
  logic                 r_dtack_n;
  logic [23:0]          r_cap_addr;
  logic [15:0]          r_cap_data;
  logic [7:0]           r_cap_status;
  logic                 r_rw;
  logic                 r_uds_n;
  logic                 r_lds_n;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic                 w_as_n;
  logic                 w_step;
  logic                 w_capture;
  logic                 w_done;
  logic                 w_ack_entry;
  logic                 w_addr0;

  // Reset asserts immediately, releases two clocks later in step with CLK_IN.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge CLK_IN or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_strb_s1     <= 3'b111;
      r_strb_s2     <= 3'b111;
      r_cmd_s1      <= 8'h00;
      r_cmd_s2      <= 8'h00;
      r_cmd_prev    <= 8'h00;
      r_cmd         <= 3'b000;
      r_toggle_prev <= 1'b0;
      r_cpu_reset_n <= 1'b0;
    end else begin
      r_strb_s1     <= {AS_N_IN, UDS_N_IN, LDS_N_IN};
      r_strb_s2     <= r_strb_s1;
      r_cmd_s1      <= CMD_IN;
      r_cmd_s2      <= r_cmd_s1;
      r_cmd_prev    <= r_cmd_s2;
      // CMD_IN moves on the SPI clock; only a value seen twice in a row is trusted.
      if (r_cmd_s2 == r_cmd_prev) r_cmd <= r_cmd_s2[2:0];
      r_toggle_prev <= r_cmd[1];
      r_cpu_reset_n <= ~r_cmd[2];
    end
  end

  assign w_as_n  = r_strb_s2[2];
  assign w_step  = r_cmd[1] ^ r_toggle_prev;
  assign w_addr0 = r_strb_s2[1] & ~r_strb_s2[0];

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_done       = 1'b0;
    if (!r_cpu_reset_n) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_as_n) begin
            w_state_next = S_WAIT;
            w_capture    = 1'b1;
          end
        end
        S_WAIT: begin
          if (w_as_n)                  w_state_next = S_IDLE;
          else if (r_wait_cnt <= 4'd1) w_state_next = r_cmd[0] ? S_HOLD : S_ACK;
        end
        S_HOLD: begin
          if (w_as_n)                    w_state_next = S_IDLE;
          else if (w_step || !r_cmd[0])  w_state_next = S_ACK;
        end
        S_ACK: begin
          if (w_as_n) begin
            w_state_next = S_IDLE;
            w_done       = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign w_ack_entry = (w_state_next == S_ACK) && (r_state != S_ACK);

  always_ff @(posedge CLK_IN or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 4'd0;
      r_dtack_n     <= 1'b1;
      r_cycle_count <= '0;
    end else begin
      r_state   <= w_state_next;
      r_dtack_n <= (w_state_next != S_ACK);
      if (w_capture)                                 r_wait_cnt <= LP_WAIT;
      else if (r_state == S_WAIT && r_wait_cnt != 0) r_wait_cnt <= r_wait_cnt - 4'd1;
      if (!r_cpu_reset_n) r_cycle_count <= '0;
      else if (w_done)    r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

  // Captures survive CPU reset and aborted cycles; only RESET_IN clears them.
  always_ff @(posedge CLK_IN or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cap_addr   <= 24'h0;
      r_cap_data   <= 16'h0;
      r_cap_status <= 8'h0;
      r_rw         <= 1'b0;
      r_uds_n      <= 1'b1;
      r_lds_n      <= 1'b1;
    end else begin
      if (w_capture) begin
        r_cap_addr <= {ADDR_IN, w_addr0};
        r_rw       <= RW_IN;
        r_uds_n    <= r_strb_s2[1];
        r_lds_n    <= r_strb_s2[0];
      end
      if (w_ack_entry) r_cap_data <= DATA_IN;
      r_cap_status <= {(r_state == S_HOLD), r_cmd[0], r_rw, ~r_uds_n, ~r_lds_n,
                       r_cycle_count[2:0]};
    end
  end

  assign DTACK_N     = r_dtack_n;
  assign CPU_RESET_N = r_cpu_reset_n;
  assign CAP_ADDR    = r_cap_addr;
  assign CAP_DATA    = r_cap_data;
  assign CAP_STATUS  = r_cap_status;
  assign CYCLE_COUNT = r_cycle_count;

endmodule

// File: doc/bus_step_controller.md
Name: bus_step_controller

Overview:
- Sits on the 68000 bus beside the SPI monitor block.
- Upstream of the monitor: latches each bus cycle's address, data and strobes into the stable ADDR/DATA/status snapshot that the monitor shifts out.
- Downstream of the monitor: consumes the monitor's received command byte to generate DTACK, single-step the CPU one bus cycle at a time, and drive CPU reset.

Parameters:
- WAIT_CYCLES, 2, CLK_IN cycles inserted between the first synchronized AS_N low and the DTACK assertion (0..15).
- CNT_WIDTH, 16, width of the free-running bus-cycle counter.

Ports:
- CLK_IN  in  1  system clock; all outputs registered on its rising edge.
- RESET_IN  in  1  asynchronous reset, active-low; asserts on the falling edge; released synchronously to CLK_IN by a 2-flop release synchronizer.
- AS_N_IN  in  1  68000 address strobe, active-low.
- UDS_N_IN  in  1  upper data strobe, active-low.
- LDS_N_IN  in  1  lower data strobe, active-low.
- RW_IN  in  1  1 = read, 0 = write.
- ADDR_IN  in  23  CPU address A23..A1.
- DATA_IN  in  16  CPU data bus D15..D0.
- CMD_IN  in  8  monitor command byte (the monitor's INPUT_SIGNAL); changes asynchronously on the SPI clock.
- DTACK_N  out  1  data transfer acknowledge to the CPU, active-low.
- CPU_RESET_N  out  1  CPU reset, active-low.
- CAP_ADDR  out  24  captured byte address for the monitor's ADDR_IN.
- CAP_DATA  out  16  captured data for the monitor's DATA_IN.
- CAP_STATUS  out  8  captured status for the monitor's OUTPUT_SIGNAL_IN.
- CYCLE_COUNT  out  CNT_WIDTH  number of completed bus cycles.

Behaviour:
- Reset values:
  - DTACK_N=1, CPU_RESET_N=0, CAP_ADDR=0, CAP_DATA=0, CAP_STATUS=0, CYCLE_COUNT=0.
  - State=IDLE; synchronizer flops cleared to their inactive levels.
- Input synchronization:
  - AS_N_IN, UDS_N_IN and LDS_N_IN pass through 2-flop synchronizers.
  - CMD_IN passes through an 8-bit 2-flop synchronizer plus a stability filter. The accepted command (CMD) updates only when the synchronized value is identical on two consecutive clocks.
- Command bits:
  - CMD[0] STEP_MODE.
  - CMD[1] STEP_TOGGLE: each change of level releases one held cycle.
  - CMD[2] CPU_HOLD_RESET: CPU_RESET_N = ~CMD[2], registered. It deasserts on the first clock after reset in which CMD[2]=0 is accepted.
  - CMD[7:3] are reserved and ignored.
- Step pulse: STEP_TOGGLE is edge-detected against its previous accepted value, giving a one-clock STEP pulse.
- FSM:
  - IDLE:
    - On synced AS_N=0, capture the cycle:
      - CAP_ADDR = {ADDR_IN, addr0}, where addr0=1 iff UDS_N=1 and LDS_N=0, else 0.
      - Latch RW and both strobes.
    - Load the wait counter with WAIT_CYCLES. Go to WAIT.
  - WAIT:
    - Decrement the counter each clock.
    - At 0: go to HOLD if STEP_MODE=1, else go to ACK.
    - WAIT_CYCLES=0 passes through WAIT in one clock.
  - HOLD:
    - DTACK_N stays 1, so the CPU inserts wait states.
    - On STEP go to ACK.
    - STEP_MODE cleared while in HOLD also goes to ACK.
  - ACK:
    - On entry, sample CAP_DATA from DATA_IN (valid for both reads and writes).
    - DTACK_N=0, held until synced AS_N=1.
    - Then: DTACK_N=1, CYCLE_COUNT+1 (wraps at 2^CNT_WIDTH-1 to 0), return to IDLE.
- AS_N rising in WAIT or HOLD (aborted cycle, e.g. bus error): return to IDLE; DTACK_N=1; no count increment; captures are retained.
- A STEP pulse that arrives outside HOLD is discarded and does not pre-arm the next cycle.
- CPU_RESET_N=0: FSM forced to IDLE, DTACK_N=1, CYCLE_COUNT cleared. Capture registers are retained.
- CAP_STATUS is updated every clock: [7]=in HOLD, [6]=STEP_MODE, [5]=latched RW, [4]=~latched UDS_N, [3]=~latched LDS_N, [2:0]=CYCLE_COUNT[2:0].
- Asserting RESET_IN mid-cycle immediately forces all reset values, including DTACK_N=1.

Test Plan:
- Reset release, CMD=0x00 -> CPU_RESET_N goes to 1 within 6 clocks; DTACK_N=1; CAP_*=0.
- Free run, WAIT_CYCLES=2. Read at A=0x123456 (ADDR_IN=0x091A2B, UDS_N=0, LDS_N=0), DATA=0xBEEF:
  - DTACK_N low 5 clocks after AS_N falls (2 sync + 1 capture + 2 wait).
  - CAP_ADDR=0x123456, CAP_DATA=0xBEEF, CAP_STATUS=0x39.
  - CYCLE_COUNT=1 after AS_N rises.
- Odd byte write (UDS_N=1, LDS_N=0, RW=0, ADDR_IN=0x000010) -> CAP_ADDR=0x000021; CAP_STATUS[5:3]=3'b001.
- Step mode:
  - CMD=0x01 -> cycle holds with CAP_STATUS[7]=1 and DTACK_N=1 for 100 clocks.
  - CMD=0x03 -> exactly one DTACK.
  - Next cycle holds until CMD=0x01.
  - A toggle sent while IDLE does not release the following cycle.
- CMD glitch: CMD_IN bit 1 pulses for 1 clock -> filter rejects it, no release. CMD=0x04 held -> CPU_RESET_N=0, FSM in IDLE, CYCLE_COUNT=0.
- AS_N deasserted during HOLD -> IDLE, no DTACK, CYCLE_COUNT unchanged. RESET_IN asserted during ACK -> DTACK_N=1 asynchronously.
